// File: rtl/obs_subproduct_sequencer.sv
// Sequences one 142-bit GF(2)[x] multiply as four odd/even half-width sub-products
// issued to a shared external multiplier, then recombines them into a 283-bit product.
module obs_subproduct_sequencer #(
    parameter int N  = 142,
    parameter int H  = 71,
    parameter int PW = 2 * H - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      a_in,
    input  logic [N-1:0]      b_in,
    output logic              busy,
    output logic              done,
    output logic [2*N-2:0]    product,
    output logic              mul_req_valid,
    input  logic              mul_req_ready,
    output logic [1:0]        mul_req_tag,
    output logic [H-1:0]      mul_op_a,
    output logic [H-1:0]      mul_op_b,
    input  logic              mul_rsp_valid,
    input  logic [1:0]        mul_rsp_tag,
    input  logic [PW-1:0]     mul_rsp_data,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_COMBINE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       cnt_r, cnt_s;
    logic [3:0]       mask_r, mask_s;
    logic             err_r, err_s;
    logic             rsp_store_s;
    logic             issued_s;
    logic [N-1:0]     a_r, b_r;
    logic [N-1:0]     a_src_s, b_src_s;
    logic [H-1:0]     a_even_s, a_odd_s, b_even_s, b_odd_s;
    logic [PW-1:0]    p1_r, p2_r, p3_r, p4_r;
    logic [2*N-2:0]   comb_s;
    logic [2*N-2:0]   product_r;
    logic             busy_r, done_r, mul_req_valid_r;
    logic [1:0]       mul_req_tag_r;
    logic [H-1:0]     mul_op_a_r, mul_op_b_r;

    // Operands for the first request come straight from the inputs in the start cycle.
    assign a_src_s = (state_r == S_IDLE) ? a_in : a_r;
    assign b_src_s = (state_r == S_IDLE) ? b_in : b_r;

    genvar g;
    for (g = 0; g < H; g++) begin : g_split
        assign a_even_s[g] = a_src_s[2*g];
        assign a_odd_s[g]  = a_src_s[2*g+1];
        assign b_even_s[g] = b_src_s[2*g];
        assign b_odd_s[g]  = b_src_s[2*g+1];
    end

    // Even bits take AeBe plus AoBo shifted by x^2; odd bits take the two cross terms.
    assign comb_s[0]       = p1_r[0];
    assign comb_s[2*N-2]   = p4_r[PW-1];
    for (g = 1; g < PW; g++) begin : g_even
        assign comb_s[2*g] = p1_r[g] ^ p4_r[g-1];
    end
    for (g = 0; g < PW; g++) begin : g_odd
        assign comb_s[2*g+1] = p2_r[g] ^ p3_r[g];
    end

    // Next-state, issue counter, response mask and protocol error.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mask_s      = mask_r;
        err_s       = err_r;
        rsp_store_s = 1'b0;
        issued_s    = (state_r == S_WAIT) || (mul_rsp_tag < cnt_r);

        if (mul_rsp_valid) begin
            if ((state_r == S_ISSUE || state_r == S_WAIT) && issued_s && !mask_r[mul_rsp_tag]) begin
                mask_s[mul_rsp_tag] = 1'b1;
                rsp_store_s         = 1'b1;
            end else begin
                err_s = 1'b1;
            end
        end else begin
            rsp_store_s = 1'b0;
        end

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_ISSUE;
                    cnt_s   = 2'd0;
                    mask_s  = 4'b0000;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mul_req_valid_r && mul_req_ready) begin
                    if (cnt_r == 2'd3) begin
                        state_s = S_WAIT;
                    end else begin
                        cnt_s = cnt_r + 2'd1;
                    end
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (mask_s == 4'b1111) begin
                    state_s = S_COMBINE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_COMBINE: state_s = S_DONE;
            S_DONE:    state_s = S_IDLE;
            default:   state_s = S_IDLE;
        endcase
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            cnt_r           <= 2'd0;
            mask_r          <= 4'b0000;
            err_r           <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            mul_req_valid_r <= 1'b0;
            mul_req_tag_r   <= 2'd0;
            mul_op_a_r      <= {H{1'b0}};
            mul_op_b_r      <= {H{1'b0}};
        end else begin
            state_r         <= state_s;
            cnt_r           <= cnt_s;
            mask_r          <= mask_s;
            err_r           <= err_s;
            busy_r          <= (state_s == S_ISSUE) || (state_s == S_WAIT) || (state_s == S_COMBINE);
            done_r          <= (state_s == S_DONE);
            mul_req_valid_r <= (state_s == S_ISSUE);
            if (state_s == S_ISSUE) begin
                mul_req_tag_r <= cnt_s;
                mul_op_a_r    <= cnt_s[1] ? a_odd_s : a_even_s;
                mul_op_b_r    <= cnt_s[0] ? b_odd_s : b_even_s;
            end
        end
    end

    // Operand capture, sub-product slots and the final product.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= {N{1'b0}};
            b_r       <= {N{1'b0}};
            p1_r      <= {PW{1'b0}};
            p2_r      <= {PW{1'b0}};
            p3_r      <= {PW{1'b0}};
            p4_r      <= {PW{1'b0}};
            product_r <= {(2*N-1){1'b0}};
        end else begin
            if (state_r == S_IDLE && start) begin
                a_r <= a_in;
                b_r <= b_in;
            end
            if (rsp_store_s) begin
                case (mul_rsp_tag)
                    2'd0:    p1_r <= mul_rsp_data;
                    2'd1:    p2_r <= mul_rsp_data;
                    2'd2:    p3_r <= mul_rsp_data;
                    2'd3:    p4_r <= mul_rsp_data;
                    default: p1_r <= p1_r;
                endcase
            end
            if (state_r == S_COMBINE) begin
                product_r <= comb_s;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign product       = product_r;
    assign mul_req_valid = mul_req_valid_r;
    assign mul_req_tag   = mul_req_tag_r;
    assign mul_op_a      = mul_op_a_r;
    assign mul_op_b      = mul_op_b_r;
    assign err           = err_r;

endmodule

// File: tb/tb_obs_subproduct_sequencer.sv
// Randomized self-checking bench: a carry-less multiply reference and a behavioural
// sub-multiplier responder exercise ordering, backpressure, errors and reset.
module tb_obs_subproduct_sequencer;
    localparam int N  = 142;
    localparam int H  = 71;
    localparam int PW = 2 * H - 1;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [N-1:0]   a_in, b_in;
    logic           busy, done, err;
    logic [2*N-2:0] product;
    logic           mul_req_valid, mul_req_ready;
    logic [1:0]     mul_req_tag;
    logic [H-1:0]   mul_op_a, mul_op_b;
    logic           mul_rsp_valid;
    logic [1:0]     mul_rsp_tag;
    logic [PW-1:0]  mul_rsp_data;

    int errors = 0;
    int checks = 0;

    // Results recorded by the transaction driver for the scenario tasks to judge.
    int             done_t, nreq, op_err, unstable;
    bit             timed_out, busy_ok;
    logic [1:0]     req_tags [4];
    logic [PW-1:0]  rsp_log [4];
    logic [2*N-2:0] prod_obs;
    logic           err_obs;

    obs_subproduct_sequencer #(.N(N), .H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .product(product),
        .mul_req_valid(mul_req_valid), .mul_req_ready(mul_req_ready),
        .mul_req_tag(mul_req_tag), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_rsp_valid(mul_rsp_valid), .mul_rsp_tag(mul_rsp_tag),
        .mul_rsp_data(mul_rsp_data), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [2*N-2:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-2:0] r = {(2*N-1){1'b0}};
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (a[i] && b[j]) r[i+j] = ~r[i+j];
        return r;
    endfunction

    function automatic logic [PW-1:0] clmul_h(input logic [H-1:0] a, input logic [H-1:0] b);
        logic [PW-1:0] r = {PW{1'b0}};
        for (int i = 0; i < H; i++)
            for (int j = 0; j < H; j++)
                if (a[i] && b[j]) r[i+j] = ~r[i+j];
        return r;
    endfunction

    function automatic logic [H-1:0] half_of(input logic [N-1:0] v, input int odd);
        logic [H-1:0] r;
        for (int i = 0; i < H; i++) r[i] = v[2*i+odd];
        return r;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [159:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[N-1:0];
    endfunction

    // Runs one multiply, acting as the external sub-multiplier (latency 1, or a fixed
    // reordered burst with a corrupted duplicate of tag 2 when reorder is set).
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall, input bit reorder);
        int t, stall_left, seq_i;
        int seq [5];
        logic hs_prev, held_v;
        logic [1:0] hs_tag, held_tag;
        logic [H-1:0] held_a, held_b, exp_a, exp_b;
        logic [PW-1:0] res [4];
        seq = '{3, 0, 2, 2, 1};
        done_t = -1; nreq = 0; op_err = 0; unstable = 0; timed_out = 1'b0; busy_ok = 1'b1;
        stall_left = stall; seq_i = 0; hs_prev = 1'b0; held_v = 1'b0; hs_tag = 2'd0;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; mul_req_ready = 1'b1;
        t = 0;
        while (t < 200) begin
            @(negedge clk);
            t++;
            start = 1'b0; a_in = rand_op(); b_in = rand_op();
            mul_rsp_valid = 1'b0; mul_rsp_tag = 2'd0; mul_rsp_data = {PW{1'b0}};
            if (done) begin
                done_t = t; prod_obs = product; err_obs = err;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (held_v && !(mul_req_valid && mul_req_tag == held_tag &&
                            mul_op_a == held_a && mul_op_b == held_b)) unstable++;
            if (!reorder && hs_prev) begin
                mul_rsp_valid = 1'b1; mul_rsp_tag = hs_tag; mul_rsp_data = res[hs_tag];
            end else if (reorder && nreq == 4 && seq_i < 5) begin
                mul_rsp_valid = 1'b1;
                mul_rsp_tag   = 2'(seq[seq_i]);
                mul_rsp_data  = (seq_i == 3) ? ~res[2] : res[seq[seq_i]];
                seq_i++;
            end
            hs_prev = 1'b0;
            if (mul_req_valid) begin
                if (stall_left > 0 && mul_req_tag == 2'd1) begin
                    mul_req_ready = 1'b0; stall_left--;
                    held_v = 1'b1; held_tag = mul_req_tag; held_a = mul_op_a; held_b = mul_op_b;
                end else begin
                    mul_req_ready = 1'b1; held_v = 1'b0;
                    if (nreq < 4) req_tags[nreq] = mul_req_tag;
                    nreq++;
                    exp_a = half_of(a, int'(mul_req_tag[1]));
                    exp_b = half_of(b, int'(mul_req_tag[0]));
                    if (mul_op_a !== exp_a || mul_op_b !== exp_b) op_err++;
                    res[mul_req_tag] = clmul_h(mul_op_a, mul_op_b);
                    rsp_log[mul_req_tag] = res[mul_req_tag];
                    hs_prev = 1'b1; hs_tag = mul_req_tag;
                end
            end else begin
                mul_req_ready = 1'b1; held_v = 1'b0;
            end
        end
        if (done_t < 0) timed_out = 1'b1;
        mul_rsp_valid = 1'b0; mul_req_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = {N{1'b0}}; b_in = {N{1'b0}};
        mul_req_ready = 1'b1; mul_rsp_valid = 1'b0; mul_rsp_tag = 2'd0; mul_rsp_data = {PW{1'b0}};
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mul_req_valid, err} !== 4'b0000 || product !== {(2*N-1){1'b0}} ||
            mul_req_tag !== 2'd0 || mul_op_a !== {H{1'b0}} || mul_op_b !== {H{1'b0}}) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b err=%b tag=%0d prod=%0h expected all zero",
                     busy, done, mul_req_valid, err, mul_req_tag, product);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_op({{(N-1){1'b0}}, 1'b1}, {{(N-1){1'b0}}, 1'b1}, 0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (done_t !== 7) begin errors++; $display("FAIL basic_latency: got %0d expected 7", done_t); end
        checks++; if (nreq !== 4) begin errors++; $display("FAIL basic_nreq: got %0d expected 4", nreq); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_tags[i] !== 2'(i)) begin errors++; $display("FAIL basic_order[%0d]: got %0d expected %0d", i, req_tags[i], i); end
        end
        checks++; if (op_err !== 0) begin errors++; $display("FAIL basic_operands: got %0d bad expected 0", op_err); end
        checks++; if (prod_obs !== clmul({{(N-1){1'b0}}, 1'b1}, {{(N-1){1'b0}}, 1'b1})) begin
            errors++; $display("FAIL basic_product: got %0h expected 1", prod_obs); end
        checks++; if (err_obs !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err_obs); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL basic_busy: got low while busy expected high"); end
        // A start presented in the DONE cycle must be ignored.
        start = 1'b1; a_in = rand_op();
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || mul_req_valid !== 1'b0) begin
            errors++; $display("FAIL done_start_ignored: got busy=%b done=%b valid=%b expected 0 0 0", busy, done, mul_req_valid); end
    endtask

    task automatic test_small();
        logic [N-1:0] x;
        x = {{(N-2){1'b0}}, 2'b10};
        do_op(x, x, 0, 1'b0);
        checks++; if (prod_obs !== clmul(x, x)) begin errors++; $display("FAIL x_times_x: got %0h expected %0h", prod_obs, clmul(x, x)); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_log[i] !== ((i == 3) ? {{(PW-1){1'b0}}, 1'b1} : {PW{1'b0}})) begin
                errors++; $display("FAIL x_subproduct[%0d]: got %0h expected %0d", i, rsp_log[i], (i == 3) ? 1 : 0); end
        end
        do_op({{(N-1){1'b0}}, 1'b1}, x, 0, 1'b0);
        checks++; if (prod_obs !== clmul({{(N-1){1'b0}}, 1'b1}, x)) begin
            errors++; $display("FAIL one_times_x: got %0h expected 2", prod_obs); end
    endtask

    task automatic test_all_ones();
        logic [2*N-2:0] exp;
        exp = clmul({N{1'b1}}, {N{1'b1}});
        do_op({N{1'b1}}, {N{1'b1}}, 0, 1'b0);
        checks++; if (prod_obs !== exp) begin errors++; $display("FAIL ones_product: got %0h expected %0h", prod_obs, exp); end
        checks++; if (prod_obs[2*N-2] !== 1'b1 || prod_obs[0] !== 1'b1) begin
            errors++; $display("FAIL ones_end_bits: got %b,%b expected 1,1", prod_obs[2*N-2], prod_obs[0]); end
    endtask

    task automatic test_stall();
        logic [N-1:0] a, b;
        a = rand_op(); b = rand_op();
        do_op(a, b, 5, 1'b0);
        checks++; if (done_t !== 12) begin errors++; $display("FAIL stall_latency: got %0d expected 12", done_t); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", unstable); end
        checks++; if (op_err !== 0) begin errors++; $display("FAIL stall_operands: got %0d bad expected 0", op_err); end
        checks++; if (prod_obs !== clmul(a, b)) begin errors++; $display("FAIL stall_product: got %0h expected %0h", prod_obs, clmul(a, b)); end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        int st;
        for (int k = 0; k < 6; k++) begin
            a = rand_op(); b = rand_op(); st = int'($urandom_range(3, 0));
            do_op(a, b, st, 1'b0);
            checks++; if (done_t !== 7 + st) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, done_t, 7 + st); end
            checks++; if (prod_obs !== clmul(a, b)) begin errors++; $display("FAIL rand_product[%0d]: got %0h expected %0h", k, prod_obs, clmul(a, b)); end
        end
    endtask

    task automatic test_reorder_dup();
        logic [N-1:0] a, b;
        a = rand_op(); b = rand_op();
        do_op(a, b, 0, 1'b1);
        checks++; if (timed_out) begin errors++; $display("FAIL reorder_timeout: got no done expected done"); end
        checks++; if (prod_obs !== clmul(a, b)) begin errors++; $display("FAIL reorder_product: got %0h expected %0h", prod_obs, clmul(a, b)); end
        checks++; if (err_obs !== 1'b1) begin errors++; $display("FAIL dup_err: got %b expected 1", err_obs); end
        a = rand_op(); b = rand_op();
        do_op(a, b, 0, 1'b0);
        checks++; if (prod_obs !== clmul(a, b)) begin errors++; $display("FAIL after_err_product: got %0h expected %0h", prod_obs, clmul(a, b)); end
        checks++; if (err_obs !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_obs); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", err); end
    endtask

    task automatic test_reset_mid();
        logic hs;
        logic [1:0] hs_tag;
        logic [PW-1:0] hs_data;
        logic [N-1:0] a, b;
        a = rand_op(); b = rand_op(); hs = 1'b0; hs_tag = 2'd0; hs_data = {PW{1'b0}};
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; mul_req_ready = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
            mul_rsp_valid = 1'b0; mul_rsp_tag = 2'd0; mul_rsp_data = {PW{1'b0}};
            if (hs && hs_tag < 2'd2) begin
                mul_rsp_valid = 1'b1; mul_rsp_tag = hs_tag; mul_rsp_data = hs_data;
            end
            hs = 1'b0;
            if (mul_req_valid) begin
                hs = 1'b1; hs_tag = mul_req_tag; hs_data = clmul_h(mul_op_a, mul_op_b);
            end
        end
        mul_rsp_valid = 1'b0;
        checks++; if (busy !== 1'b1 || mul_req_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_wait_state: got busy=%b valid=%b done=%b expected 1 0 0", busy, mul_req_valid, done); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || mul_req_valid !== 1'b0 || product !== {(2*N-1){1'b0}} || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got busy=%b valid=%b prod=%0h expected 0 0 0", busy, mul_req_valid, product); end
        // A stale response after reset must be flagged.
        mul_rsp_valid = 1'b1; mul_rsp_tag = 2'd2; mul_rsp_data = hs_data;
        @(negedge clk);
        mul_rsp_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stale_rsp_err: got %b expected 1", err); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a = rand_op(); b = rand_op();
        do_op(a, b, 0, 1'b0);
        checks++; if (done_t !== 7) begin errors++; $display("FAIL post_reset_latency: got %0d expected 7", done_t); end
        checks++; if (prod_obs !== clmul(a, b) || err_obs !== 1'b0) begin
            errors++; $display("FAIL post_reset_op: got %0h err=%b expected %0h err=0", prod_obs, err_obs, clmul(a, b)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small();
        test_all_ones();
        test_stall();
        test_random();
        test_reorder_dup();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
